// File: rtl/addsub_seq.sv
// addsub_seq: multi-word add/subtract sequencer driving one external 32-bit adder (optional ADDSEQ_OVERFLOW_EN)
module addsub_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic                cin,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [32*WORDS-1:0] result,
    output logic                cout,
    output logic                ovf,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    output logic                add_cin,
    input  logic [31:0]         add_sum,
    input  logic                add_cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [32*WORDS-1:0] a_r, b_r;
    logic op_r, carry;
    logic [2:0] idx;
    logic [31:0] b_w;
    assign add_a = a_r[idx*32 +: 32];
    assign b_w = b_r[idx*32 +: 32];
    assign add_b = op_r ? ~b_w : b_w;
    assign add_cin = carry;
`ifndef ADDSEQ_OVERFLOW_EN
    assign ovf = 1'b0;
`endif
    // sequencer: latch operands, step one word per cycle, chain carry, assemble result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
`ifdef ADDSEQ_OVERFLOW_EN
            ovf    <= 1'b0;
`endif
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
        end else if (state == RUN) begin
            result[idx*32 +: 32] <= add_sum;
            carry <= add_cout;
            if (idx == 3'(WORDS - 1)) begin
                cout  <= add_cout;
`ifdef ADDSEQ_OVERFLOW_EN
                ovf   <= (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
`endif
                idx   <= '0;
                state <= DONE;
                ready <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                idx <= idx + 3'd1;
            end
        end else if (start) begin
            a_r    <= a;
            b_r    <= b;
            op_r   <= op;
            carry  <= op ? 1'b1 : cin;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
`ifdef ADDSEQ_OVERFLOW_EN
            ovf    <= 1'b0;
`endif
            state  <= RUN;
            ready  <= 1'b0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed self-checking bench for addsub_seq with a behavioural 32-bit adder
module tb_addsub_seq;
    localparam int WORDS = 4;
    localparam int W = 32 * WORDS;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, op = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic ready, busy, done, cout, ovf, add_cin, add_cout;
    logic [W-1:0] result;
    logic [31:0] add_a, add_b, add_sum;
    int n_checks = 0, n_fail = 0, cyc = 0;
    logic exp_ovf_bit;

    addsub_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic o, input logic c, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] er, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        op = o; cin = c; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~y; op = ~o;
        check({tag, " busy"}, busy, 1);
        wait_done(lat);
        check({tag, " latency"}, lat, WORDS);
        check({tag, " result"}, result, er);
        check({tag, " cout"}, cout, ec);
        check({tag, " ovf"}, ovf, eo);
    endtask

    initial begin
        int lat, t1, t2, pulses;
`ifdef ADDSEQ_OVERFLOW_EN
        exp_ovf_bit = 1'b1;
`else
        exp_ovf_bit = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset ready", ready, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset cout", cout, 0);
        check("reset ovf", ovf, 0);
        rst = 1'b0;

        do_op("ripple", 0, 0, {W{1'b1}}, 1, 0, 1, 0);
        do_op("borrow", 1, 0, 0, 1, {W{1'b1}}, 0, 0);
        do_op("overflow", 0, 0, {1'b0, {(W-1){1'b1}}}, 1, {1'b1, {(W-1){1'b0}}}, 0, exp_ovf_bit);
        do_op("add cin", 0, 1, 5, 7, 13, 0, 0);
        do_op("sub cin ignored", 1, 1, 10, 3, 7, 1, 0);
        do_op("words", 0, 0, 128'h00000000_FFFFFFFF_00000000_FFFFFFFF,
              128'h00000000_00000001_00000000_00000001,
              128'h00000001_00000000_00000001_00000000, 0, 0);

        // reset mid-RUN at idx=2
        @(negedge clk);
        op = 0; cin = 0; a = 5; b = 7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midrun busy before rst", busy, 1);
        rst = 1'b1;
        #1;
        check("midrun rst ready", ready, 1);
        check("midrun rst busy", busy, 0);
        check("midrun rst done", done, 0);
        check("midrun rst result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrun no done", pulses, 0);

        // back-to-back with start held through DONE
        @(negedge clk);
        op = 0; cin = 0; a = 100; b = 23; start = 1'b1;
        @(negedge clk);
        a = 40; b = 2;
        wait_done(lat);
        t1 = cyc;
        check("b2b first result", result, 123);
        @(negedge clk);
        start = 1'b0;
        check("b2b accepted in DONE", busy, 1);
        wait_done(lat);
        t2 = cyc;
        check("b2b spacing", t2 - t1, WORDS + 1);
        check("b2b second result", result, 42);

        // start pulsed during RUN is ignored
        @(negedge clk);
        op = 0; cin = 0; a = 5; b = 7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 1000; b = 1000;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("run start pulses", pulses, 1);
        check("run start result", result, 12);
        check("run start idle", ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-word add/subtract sequencer that drives one external 32-bit ripple-carry adder over several clock cycles to produce a WORDS×32-bit sum or difference. It latches wide operands on a start handshake and presents one 32-bit word pair per cycle to the adder, least significant word first. The adder's carry-out is registered and fed back as the next word's carry-in. The block sits between the wide-arithmetic requester and the shared 32-bit adder macro and owns all sequencing, carry chaining and result assembly.

## Interface
Parameters:
- WORDS, 4, number of 32-bit words per operand; legal range 2..8; operand width W = 32*WORDS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- op  input  1  0 = add, 1 = subtract (a − b).
- cin  input  1  initial carry for add; ignored for subtract.
- a  input  W  operand A, sampled with start.
- b  input  W  operand B, sampled with start.
- ready  output  1  high in IDLE and DONE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- result  output  W  assembled result; held until the next accepted start.
- cout  output  1  final carry-out (subtract: 1 = no borrow).
- ovf  output  1  signed overflow; see Configuration.
- add_a  output  32  word of latched A at index idx.
- add_b  output  32  word of latched B at idx, bitwise inverted when op=1.
- add_cin  output  1  carry register.
- add_sum  input  32  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.

## Operation
- States: IDLE, RUN, DONE. idx is a 3-bit word counter.
- IDLE or DONE with start=1:
  - latch a, b and op;
  - set the carry register to (op ? 1 : cin);
  - clear idx;
  - clear result, cout and ovf;
  - go to RUN.
- RUN, at each edge:
  - result word idx ← add_sum;
  - carry ← add_cout;
  - if idx = WORDS−1: cout ← add_cout, update ovf, go to DONE;
  - else idx ← idx+1.
- DONE with start=0: go to IDLE.
- start while busy=1 is ignored. No queueing and no error flag.
- Subtract is two's complement: ~B plus an initial carry of 1.
- add_a, add_b and add_cin are driven from registers only, with no input-to-output combinational path. In IDLE and DONE they are driven with the word-0 values.
- An input change on a or b after acceptance has no effect.

## Timing
- Reset values: state IDLE, ready=1, busy=0, done=0, result=0, cout=0, ovf=0, idx=0, carry=0.
- Start is accepted at edge E0. busy is high for cycles E0..E(WORDS). done is high for exactly one cycle after edge E(WORDS).
- Latency from start to done is WORDS cycles.
- Throughput with start held high in DONE: one operation per WORDS+1 cycles.
- done and the new result/cout/ovf become valid in the same cycle.
- Asserting rst in any state, including mid-RUN, returns all registers to their reset values immediately. A partial result is discarded, and no done pulse follows.
- The external adder's ripple delay must fit within one clk period. The block adds no wait states.

## Configuration
- ADDSEQ_OVERFLOW_EN defined:
  - ovf ← (a_msb == b'_msb) && (add_sum[31] != a_msb) on the final word;
  - b' is the inverted B for subtract.
- ADDSEQ_OVERFLOW_EN undefined: ovf is tied to 0 and no overflow logic is built.

## Test plan
- Reset check: WORDS=4, hold rst high mid-RUN at idx=2. Required: ready=1, busy=0, done=0, result=0 immediately; no done pulse follows.
- Carry ripple across all words: WORDS=4, add a=2^128−1, b=1, cin=0. Required: done 4 cycles after start, result=0, cout=1, ovf=0.
- Subtract with borrow: a=0, b=1, op=1. Required: result=all ones, cout=0, ovf=0.
- Signed overflow with ADDSEQ_OVERFLOW_EN defined: a=0x7FFF…F, b=1, add. Required: result=0x8000…0, ovf=1. Without the macro, ovf=0.
- Back-to-back operation: hold start high while in DONE. Required: the second operation is accepted in the DONE cycle and its done pulse occurs exactly 5 cycles after the first.
- start pulsed during RUN: Required: it is ignored, the result is unchanged, and only one done pulse occurs.
